pll_reset_sequencer: RTL

- Parametrised reset sequencer for the PLL-derived clock domains exported by the system (VGA, M10K, compute and future domains).
- Watches N PLL "locked" inputs and requires them to be continuously stable before releasing each enabled channel's active-low reset, one channel at a time in ascending order.
- Re-asserts all resets and records the cause on any loss of lock or on a software reset request.
- Sits in the reference-clock domain between the Computer_System PLL outputs and the user-logic reset trees.

---
 rtl/pll_rst_pkg.sv | 18 +
 rtl/pll_reset_sequencer_bit_sync.sv | 23 ++
 rtl/pll_reset_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pll_rst_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_rst_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_e;

    localparam int MAX_CH = 16;

    function automatic int cnt_width(input int max_count);
        return $clog2(max_count) + 1;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_bit_sync.sv
// Multi-stage single-bit synchronizer with asynchronous active-low reset.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Releases per-domain resets in ascending channel order once all enabled PLLs
// have held lock long enough; re-asserts everything on lock loss or SW request.
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int STABLE_CYCLES = 1024,
    parameter int GAP_CYCLES    = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [NUM_CH-1:0] locked_i,
    input  logic [NUM_CH-1:0] ch_enable_i,
    input  logic              sw_reset_req_i,
    input  logic              sticky_clear_i,
    output logic [NUM_CH-1:0] rst_n_o,
    output logic              all_ready_o,
    output logic [NUM_CH-1:0] lock_lost_o,
    output logic [2:0]        state_o
);

    localparam int CNT_MAX = (STABLE_CYCLES > GAP_CYCLES) ? STABLE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam int HOLD_W  = cnt_width(GAP_CYCLES);
    localparam int IDX_W   = $clog2(MAX_CH);

    localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD   = HOLD_W'(GAP_CYCLES);

    logic [NUM_CH-1:0] lk;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
        bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk_i  (clk_clk),
            .rst_ni (reset_reset_n),
            .d_i    (locked_i[g]),
            .q_o    (lk[g])
        );
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] rst_n_q, rst_n_d;
    logic [NUM_CH-1:0] lost_q, lost_d;
    logic [NUM_CH-1:0] lost_set;

    logic             ok, ok_live;
    logic             first_found, next_found;
    logic [IDX_W-1:0] first_idx, next_idx;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Before the mask is captured the live enables decide; afterwards only en_q.
    assign ok      = &(lk | ~en_q);
    assign ok_live = &(lk | ~ch_enable_i);

    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (en_q[i] && !first_found) begin
                first_found = 1'b1;
                first_idx   = IDX_W'(i);
            end
            if (en_q[i] && !next_found && (i > int'(idx_q))) begin
                next_found = 1'b1;
                next_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        idx_d    = idx_q;
        en_d     = en_q;
        rst_n_d  = rst_n_q;
        lost_set = '0;

        unique case (state_q)
            WAIT_LOCK: begin
                rst_n_d = '0;
                cnt_d   = '0;
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else if (ok_live) begin
                    state_d = STABLE;
                    en_d    = ch_enable_i;
                end
            end
            STABLE: begin
                rst_n_d = '0;
                if (!ok) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q >= STABLE_LAST) begin
                    cnt_d = '0;
                    if (first_found) begin
                        state_d = RELEASE;
                        idx_d   = first_idx;
                        rst_n_d = NUM_CH'(1) << first_idx;
                    end else begin
                        state_d = RUN;
                        rst_n_d = en_q;
                    end
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            RELEASE: begin
                if (!ok) begin
                    state_d  = FAULT;
                    cnt_d    = '0;
                    rst_n_d  = '0;
                    lost_set = en_q & ~lk;
                end else if (cnt_q >= GAP_LAST) begin
                    cnt_d = '0;
                    if (next_found) begin
                        idx_d   = next_idx;
                        rst_n_d = rst_n_q | (NUM_CH'(1) << next_idx);
                    end else begin
                        state_d = RUN;
                        rst_n_d = en_q;
                    end
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            RUN: begin
                rst_n_d = en_q;
                if (!ok) begin
                    state_d  = FAULT;
                    rst_n_d  = '0;
                    lost_set = en_q & ~lk;
                end
            end
            FAULT: begin
                rst_n_d = '0;
                cnt_d   = '0;
                state_d = WAIT_LOCK;
                hold_d  = HOLD_LOAD;
            end
            default: begin
                rst_n_d = '0;
                cnt_d   = '0;
                state_d = WAIT_LOCK;
            end
        endcase

        // A software restart overrides the FSM but a coincident loss is still recorded.
        if (sw_reset_req_i) begin
            state_d = WAIT_LOCK;
            hold_d  = HOLD_LOAD;
            cnt_d   = '0;
            rst_n_d = '0;
        end

        lost_d = (sticky_clear_i ? '0 : lost_q) | lost_set;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            hold_q  <= '0;
            idx_q   <= '0;
            en_q    <= '0;
            rst_n_q <= '0;
            lost_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            rst_n_q <= rst_n_d;
            lost_q  <= lost_d;
        end
    end

    assign rst_n_o     = rst_n_q;
    assign all_ready_o = (state_q == RUN);
    assign lock_lost_o = lost_q;
    assign state_o     = state_q;

endmodule
